// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0, MSB-first master sequencer for an external 8-bit shift register.
// Optional macro SPI_BURST_EN: back-to-back bytes with CS_N held low between them.
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       START,
   input  logic [7:0] TX_DATA,
   output logic       READY,
   output logic       DONE,
   output logic [7:0] RX_DATA,
   output logic       SCLK,
   output logic       CS_N,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SR_CLK,
   output logic       SR_SH_LD,
   output logic       SR_SDI,
   input  logic [7:0] SR_DATA
);
   localparam int unsigned DIV_W = 8;
   localparam int unsigned BIT_W = 4;
   localparam int unsigned NBITS = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD0, S_LOAD1, S_SETUP, S_HIGH, S_LOW, S_HOLD
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             div_last;
   logic             timed;
   logic             unused_tx;

   // TX_DATA feeds the shift register's parallel input directly; the load strobe captures it.
   assign unused_tx = ^TX_DATA;
   assign MOSI      = SR_DATA[7];
   assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign timed     = (state == S_SETUP) || (state == S_HIGH) ||
                      (state == S_LOW)   || (state == S_HOLD);

`ifdef SPI_BURST_EN
   logic hold_pre_last;
   assign hold_pre_last = (CLK_DIV > 1) && (div_cnt == DIV_W'(CLK_DIV - 2));
`endif

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state    <= S_IDLE;
         READY    <= 1'b1;
         DONE     <= 1'b0;
         RX_DATA  <= '0;
         SCLK     <= 1'b0;
         CS_N     <= 1'b1;
         SR_CLK   <= 1'b0;
         SR_SH_LD <= 1'b1;
         SR_SDI   <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
      end else begin
         DONE   <= 1'b0;
         SR_CLK <= 1'b0;
         if (timed)
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;

         unique case (state)
            S_IDLE: begin
               if (START) begin
                  state    <= S_LOAD0;
                  READY    <= 1'b0;
                  SR_SH_LD <= 1'b0;
                  bit_cnt  <= '0;
               end
            end
            S_LOAD0: begin
               state  <= S_LOAD1;
               SR_CLK <= 1'b1;
            end
            S_LOAD1: begin
               state    <= S_SETUP;
               SR_SH_LD <= 1'b1;
               CS_N     <= 1'b0;
            end
            S_SETUP: begin
               if (div_last) begin
                  state  <= S_HIGH;
                  SCLK   <= 1'b1;
                  SR_SDI <= MISO;
               end
            end
            S_HIGH: begin
               // Falling SCLK shifts the sampled bit into the register
               if (div_last) begin
                  state   <= S_LOW;
                  SCLK    <= 1'b0;
                  SR_CLK  <= 1'b1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_LOW: begin
               if (div_last) begin
                  if (bit_cnt == BIT_W'(NBITS)) begin
                     state <= S_HOLD;
`ifdef SPI_BURST_EN
                     READY <= (CLK_DIV == 1);
`endif
                  end else begin
                     state  <= S_HIGH;
                     SCLK   <= 1'b1;
                     SR_SDI <= MISO;
                  end
               end
            end
            S_HOLD: begin
`ifdef SPI_BURST_EN
               if (!div_last && hold_pre_last)
                  READY <= 1'b1;
`endif
               if (div_last) begin
                  RX_DATA <= SR_DATA;
                  DONE    <= 1'b1;
`ifdef SPI_BURST_EN
                  if (START) begin
                     state    <= S_LOAD0;
                     READY    <= 1'b0;
                     SR_SH_LD <= 1'b0;
                     bit_cnt  <= '0;
                  end else begin
                     state <= S_IDLE;
                     CS_N  <= 1'b1;
                     READY <= 1'b1;
                  end
`else
                  state <= S_IDLE;
                  CS_N  <= 1'b1;
                  READY <= 1'b1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized self-checking bench for spi_master_ctrl with a shift-register model.
module tb_spi_master_ctrl;
   localparam int unsigned DIV  = 4;
   localparam int unsigned XFER = 3 + 18 * DIV;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic       START = 1'b0;
   logic [7:0] TX_DATA = 8'h00;
   logic       READY, DONE, SCLK, CS_N, MOSI, MISO;
   logic       SR_CLK, SR_SH_LD, SR_SDI;
   logic [7:0] RX_DATA, SR_DATA;

   spi_master_ctrl #(.CLK_DIV(DIV)) dut (
      .CLK(CLK), .CLR(CLR), .START(START), .TX_DATA(TX_DATA),
      .READY(READY), .DONE(DONE), .RX_DATA(RX_DATA),
      .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
      .SR_CLK(SR_CLK), .SR_SH_LD(SR_SH_LD), .SR_SDI(SR_SDI), .SR_DATA(SR_DATA)
   );

   always #5 CLK = ~CLK;

   // 8-bit parallel-load / serial-shift register driven by the controller strobes
   logic [7:0] sr_q = 8'h00;
   assign SR_DATA = sr_q;
   always @(posedge SR_CLK)
      sr_q <= SR_SH_LD ? {sr_q[6:0], SR_SDI} : TX_DATA;

   // MISO source: 0 = looped to MOSI, 1 = tied high, 2 = random bits
   int   mmode = 0;
   logic miso_drv = 1'b0;
   assign MISO = (mmode == 0) ? MOSI : (mmode == 1) ? 1'b1 : miso_drv;

   int          cyc = 0;
   int          rise_cnt = 0, done_cnt = 0, done_cyc = 0, cs_rise = 0, dbl = 0;
   logic [15:0] mosi_hist = '0, miso_hist = '0;
   logic        sclk_q = 1'b0, cs_q = 1'b1, srclk_q = 1'b0;
   logic [7:0]  rx_log[$];
   int          total = 0, bad = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Bus monitor: records bit values at SCLK rises, DONE pulses and strobe hazards
   always @(negedge CLK) begin
      if (SCLK && !sclk_q) begin
         rise_cnt++;
         mosi_hist = {mosi_hist[14:0], MOSI};
         miso_hist = {miso_hist[14:0], MISO};
      end
      if (CS_N && !cs_q) cs_rise++;
      if (SR_CLK && srclk_q) dbl++;
      if (DONE) begin
         done_cnt++;
         done_cyc = cyc;
         rx_log.push_back(RX_DATA);
      end
      sclk_q  = SCLK;
      cs_q    = CS_N;
      srclk_q = SR_CLK;
      if (!SCLK) miso_drv = 1'($urandom);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Raise START with a byte and wait for the cycle in which READY accepts it
   task automatic accept(input logic [7:0] b, input bit hold, output int t0);
      bit found = 1'b0;
      t0 = 0;
      @(negedge CLK);
      TX_DATA = b;
      START   = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (READY) begin
            t0    = cyc;
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk("accept_timeout", 32'(found), 32'd1);
      if (!hold) begin
         @(posedge CLK);
         #1 START = 1'b0;
      end
   endtask

   task automatic wait_done(input int target);
      for (int n = 0; n < 1000 && done_cnt < target; n++) @(negedge CLK);
      chk("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   int          t0, t1, d0, r0, c0, s0;
   logic [7:0]  b, exp_rx;

   initial begin
      // Reset
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", 32'(READY), 32'd1);
      chk("rst_cs_n", 32'(CS_N), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_rx", 32'(RX_DATA), 32'h00);
      chk("rst_sh_ld", 32'(SR_SH_LD), 32'd1);
      chk("rst_sr_clk", 32'(SR_CLK), 32'd0);
      CLR = 1'b1;
      s0 = dbl;

      // Single byte, looped back
      d0 = done_cnt; r0 = rise_cnt;
      accept(8'hA5, 1'b0, t0);
      repeat (10) @(negedge CLK);
      chk("busy_ready", 32'(READY), 32'd0);
      chk("busy_cs_n", 32'(CS_N), 32'd0);
      wait_done(d0 + 1);
      chk("a5_latency", 32'(done_cyc - t0), 32'(XFER));
      chk("a5_rx", 32'(RX_DATA), 32'hA5);
      chk("a5_mosi", 32'(mosi_hist[7:0]), 32'hA5);
      chk("a5_rises", 32'(rise_cnt - r0), 32'd8);

      // MISO tied high, zero byte out
      mmode = 1; d0 = done_cnt; r0 = rise_cnt;
      accept(8'h00, 1'b0, t0);
      wait_done(d0 + 1);
      chk("ff_rx", 32'(RX_DATA), 32'hFF);
      chk("ff_mosi", 32'(mosi_hist[7:0]), 32'h00);
      chk("ff_latency", 32'(done_cyc - t0), 32'(XFER));
      mmode = 0;

      // START held through the busy period: no queued transfer
      d0 = done_cnt; r0 = rise_cnt;
      accept(8'h81, 1'b1, t0);
      repeat (5) @(negedge CLK);
      TX_DATA = 8'h3C;
      repeat (35) @(negedge CLK);
      START = 1'b0;
      wait_done(d0 + 1);
      repeat (150) @(negedge CLK);
      chk("held_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("held_rx", 32'(RX_DATA), 32'h81);
      chk("held_rises", 32'(rise_cnt - r0), 32'd8);

      // Abort mid-byte, then a clean transfer
      d0 = done_cnt; r0 = rise_cnt;
      accept(8'hC3, 1'b0, t0);
      for (int n = 0; n < 200 && (rise_cnt - r0) < 4; n++) @(negedge CLK);
      chk("abort_reach", 32'(rise_cnt - r0), 32'd4);
      CLR = 1'b0;
      @(negedge CLK);
      chk("abort_cs_n", 32'(CS_N), 32'd1);
      chk("abort_sclk", 32'(SCLK), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      chk("abort_ready", 32'(READY), 32'd1);
      CLR = 1'b1;
      repeat (120) @(negedge CLK);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      accept(8'h5A, 1'b0, t0);
      wait_done(d0 + 1);
      chk("after_abort_rx", 32'(RX_DATA), 32'h5A);
      chk("after_abort_lat", 32'(done_cyc - t0), 32'(XFER));

      // Back-to-back bytes
      d0 = done_cnt; r0 = rise_cnt; c0 = cs_rise;
      accept(8'h12, 1'b0, t0);
      repeat (5) @(negedge CLK);
      accept(8'h34, 1'b0, t1);
      wait_done(d0 + 2);
      repeat (2) @(negedge CLK);
      chk("b2b_rx1", 32'(rx_log[d0]), 32'h12);
      chk("b2b_rx2", 32'(RX_DATA), 32'h34);
      chk("b2b_rises", 32'(rise_cnt - r0), 32'd16);
      chk("b2b_mosi", 32'(mosi_hist), 32'h1234);
      chk("b2b_lat2", 32'(done_cyc - t1), 32'(XFER));
`ifdef SPI_BURST_EN
      chk("b2b_gap", 32'(t1 - t0), 32'(XFER - 1));
      chk("b2b_cs_rises", 32'(cs_rise - c0), 32'd1);
`else
      chk("b2b_gap", 32'(t1 - t0), 32'(XFER));
      chk("b2b_cs_rises", 32'(cs_rise - c0), 32'd2);
`endif

      // Randomized bytes and MISO sources against the reference model
      for (int i = 0; i < 16; i++) begin
         b     = 8'($urandom);
         mmode = int'($urandom_range(0, 2));
         d0 = done_cnt; r0 = rise_cnt;
         accept(b, 1'b0, t0);
         wait_done(d0 + 1);
         exp_rx = (mmode == 0) ? b : (mmode == 1) ? 8'hFF : miso_hist[7:0];
         chk("rnd_rx", 32'(RX_DATA), 32'(exp_rx));
         chk("rnd_mosi", 32'(mosi_hist[7:0]), 32'(b));
         chk("rnd_lat", 32'(done_cyc - t0), 32'(XFER));
         chk("rnd_rises", 32'(rise_cnt - r0), 32'd8);
         repeat ($urandom_range(0, 5)) @(negedge CLK);
      end

      chk("sr_clk_double", 32'(dbl - s0), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
